// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, GF(2^8) helpers, S-box tables and
// the decryptor FSM state type.
package aes_pkg;

    localparam int unsigned NR = 10;
    localparam int unsigned NK = 4;

    typedef enum logic [2:0] {
        IDLE,
        KEY_EXP,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // Byte 0 sits in the most significant position, matching FIPS-197 order.
    typedef logic [0:15][7:0] block_t;

    // Entry 0 and entries 11..15 are never used by the key schedule.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX_TBL [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX_TBL [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[b];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns; i_final skips
// InvMixColumns for the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_final,
    output logic [127:0] o_state
);

    block_t w_in;
    block_t w_sub;
    block_t w_ark;
    block_t w_mix;

    function automatic logic [31:0] inv_mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                                input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        b0 = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
        b1 = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
        b2 = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
        b3 = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte b = 4*col + row; row r is rotated right by r positions before substitution.
    always_comb begin
        w_in  = i_state;
        w_sub = '0;
        w_mix = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                w_sub[4'(4 * c + r)] = inv_sbox(w_in[4'(4 * ((c + 4 - r) % 4) + r)]);
            end
        end
        w_ark = w_sub ^ i_rk;
        for (int unsigned c = 0; c < 4; c++) begin
            {w_mix[4'(4 * c)], w_mix[4'(4 * c + 1)], w_mix[4'(4 * c + 2)], w_mix[4'(4 * c + 3)]} =
                inv_mix_col(w_ark[4'(4 * c)], w_ark[4'(4 * c + 1)],
                            w_ark[4'(4 * c + 2)], w_ark[4'(4 * c + 3)]);
        end
        o_state = i_final ? w_ark : w_mix;
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryptor, one inverse round per clock.
// Key schedule is expanded forward (one key per cycle) into local storage.
// Build option AES_INV_KEY_CACHE_EN: a start with key_same=1 reuses the
// stored schedule when it is valid and skips the expansion phase.
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [0:127] Key,
    input  logic [0:127] Data_In,
    input  logic         key_same,
    output logic         busy,
    output logic         done,
    output logic [0:127] Data_Out
);

`ifdef AES_INV_KEY_CACHE_EN
    localparam logic CACHE_EN = 1'b1;
`else
    localparam logic CACHE_EN = 1'b0;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_round;
    logic       r_cache_vld;
    block_t     r_ct;
    block_t     r_blk;
    block_t     r_prev_key;
    block_t     r_dout;
    block_t     r_rk [0:NR];
    block_t     w_next_key;
    block_t     w_rk_sel;
    block_t     w_round_out;
    logic       w_use_cache;
    logic       w_final;

    // Forward expansion step: rk[i] from rk[i-1] and Rcon[i].
    function automatic block_t next_round_key(input block_t prev, input logic [7:0] rc);
        block_t     nxt;
        logic [7:0] t [4];
        t[0] = sbox(prev[13]) ^ rc;
        t[1] = sbox(prev[14]);
        t[2] = sbox(prev[15]);
        t[3] = sbox(prev[12]);
        nxt  = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            nxt[4'(j)] = prev[4'(j)] ^ t[2'(j)];
        end
        for (int unsigned i = 1; i < NK; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                nxt[4'(4 * i + j)] = prev[4'(4 * i + j)] ^ nxt[4'(4 * (i - 1) + j)];
            end
        end
        return nxt;
    endfunction

    assign w_use_cache = CACHE_EN & key_same & r_cache_vld;
    assign w_next_key  = next_round_key(r_prev_key, RCON[r_round]);
    assign w_final     = (r_state == FINAL);
    assign w_rk_sel    = w_final ? r_rk[0] : r_rk[r_round];
    assign Data_Out    = r_dout;

    aes_inv_round u_round (
        .i_state (r_blk),
        .i_rk    (w_rk_sel),
        .i_final (w_final),
        .o_state (w_round_out)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // FSM next-state logic; starts outside IDLE (including DONE) are dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_use_cache ? INIT : KEY_EXP;
            KEY_EXP: if (r_round == 4'(NR)) w_next = INIT;
            INIT:    w_next = ROUND;
            ROUND:   if (r_round == 4'd1) w_next = FINAL;
            FINAL:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Round counter, cache flag and output register (reset-controlled).
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_round     <= '0;
            r_cache_vld <= 1'b0;
            r_dout      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_round <= 4'd1;
                        if (!w_use_cache) r_cache_vld <= 1'b0;
                    end
                end
                KEY_EXP: begin
                    if (r_round == 4'(NR)) r_cache_vld <= 1'b1;
                    else                   r_round     <= r_round + 4'd1;
                end
                INIT:    r_round <= 4'(NR - 1);
                ROUND:   r_round <= r_round - 4'd1;
                FINAL:   r_dout  <= w_round_out;
                default: ;
            endcase
        end
    end

    // Datapath and round-key storage; no reset needed, validity lives in r_cache_vld.
    always_ff @(posedge CLK) begin
        case (r_state)
            IDLE: begin
                if (start) begin
                    r_ct       <= Data_In;
                    r_prev_key <= Key;
                    if (!w_use_cache) r_rk[0] <= Key;
                end
            end
            KEY_EXP: begin
                r_prev_key       <= w_next_key;
                r_rk[r_round]    <= w_next_key;
            end
            INIT:    r_blk <= r_ct ^ r_rk[NR];
            ROUND:   r_blk <= w_round_out;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher: randomized round-trip bench. Ciphertexts for random
// cases come from a forward AES-128 model whose S-box is derived from the
// field inverse and affine map, independent of the design's tables.
module tb_aes_inv_cipher;

    logic         CLK;
    logic         RST;
    logic         start;
    logic         key_same;
    logic [127:0] Key;
    logic [127:0] Data_In;
    logic         busy;
    logic         done;
    logic [127:0] Data_Out;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [256];

`ifdef AES_INV_KEY_CACHE_EN
    localparam int CACHED_LAT = 11;
`else
    localparam int CACHED_LAT = 21;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_cipher dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .Key      (Key),
        .Data_In  (Data_In),
        .key_same (key_same),
        .busy     (busy),
        .done     (done),
        .Data_Out (Data_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less product reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128 encryption, byte b = row + 4*col.
    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8 * b -: 8] ^ w[b / 4][31 - 8 * (b % 4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int b = 0; b < 16; b++) s[b] = sb[s[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
            s = t;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    t[4 * c]     = gmul(s[4 * c], 8'h02) ^ gmul(s[4 * c + 1], 8'h03) ^ s[4 * c + 2] ^ s[4 * c + 3];
                    t[4 * c + 1] = s[4 * c] ^ gmul(s[4 * c + 1], 8'h02) ^ gmul(s[4 * c + 2], 8'h03) ^ s[4 * c + 3];
                    t[4 * c + 2] = s[4 * c] ^ s[4 * c + 1] ^ gmul(s[4 * c + 2], 8'h02) ^ gmul(s[4 * c + 3], 8'h03);
                    t[4 * c + 3] = gmul(s[4 * c], 8'h03) ^ s[4 * c + 1] ^ s[4 * c + 2] ^ gmul(s[4 * c + 3], 8'h02);
                end
                s = t;
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4 * rnd + b / 4][31 - 8 * (b % 4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127 - 8 * b -: 8] = s[b];
        return res;
    endfunction

    // One decrypt; optional extra start pulse sampled at edge spur_edge.
    task automatic run_op(input logic [127:0] key, input logic [127:0] ct, input logic ks,
                          input int spur_edge, output int lat, output int ndone,
                          output logic [127:0] pt, output logic busy_ok);
        lat = -1; ndone = 0; pt = '0; busy_ok = 1'b1;
        @(negedge CLK);
        Key = key; Data_In = ct; key_same = ks; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0; key_same = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            if (e == spur_edge) begin
                start = 1'b1; Data_In = ~ct; Key = ~key;
            end
            @(posedge CLK);
            @(negedge CLK);
            start = 1'b0;
            if (lat < 0 && !busy) busy_ok = 1'b0;
            if (lat > 0 && e == lat + 1 && busy) busy_ok = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = e;
                    pt  = Data_Out;
                end
            end
        end
    endtask

    task automatic op_check(input string tag, input logic [127:0] key, input logic [127:0] ct,
                            input logic ks, input int spur_edge, input logic [127:0] exp_pt,
                            input int exp_lat);
        int lat;
        int ndone;
        logic [127:0] pt;
        logic busy_ok;
        run_op(key, ct, ks, spur_edge, lat, ndone, pt, busy_ok);
        check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
        check({tag, ".ndone"}, 128'(ndone), 128'd1);
        check({tag, ".plain"}, pt, exp_pt);
        check({tag, ".busy"}, 128'(busy_ok), 128'd1);
    endtask

    initial begin
        logic [127:0] rk;
        logic [127:0] rp;
        int nd;
        build_sbox();
        RST = 1'b0; start = 1'b0; key_same = 1'b0; Key = '0; Data_In = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset.busy", 128'(busy), 128'd0);
        check("reset.done", 128'(done), 128'd0);
        check("reset.dout", Data_Out, 128'd0);
        RST = 1'b1;

        op_check("c1", K1, C1, 1'b0, 0, P1, 21);
        op_check("appB", K2, C2, 1'b0, 0, P2, 21);
        op_check("start_busy", K1, C1, 1'b0, 5, P1, 21);
        op_check("start_done", K2, C2, 1'b0, 22, P2, 21);

        // Reset asserted so that edge 12 samples RST=0.
        @(negedge CLK);
        Key = K2; Data_In = C2; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (11) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("midrst.busy", 128'(busy), 128'd0);
        check("midrst.done", 128'(done), 128'd0);
        check("midrst.dout", Data_Out, 128'd0);
        RST = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge CLK);
            if (done) nd++;
        end
        check("midrst.nodone", 128'(nd), 128'd0);
        check("midrst.hold", Data_Out, 128'd0);
        op_check("post_rst", K1, C1, 1'b0, 0, P1, 21);

        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            op_check($sformatf("rand%0d", i), rk, aes_enc(rk, rp), 1'b0, 0, rp, 21);
        end

        op_check("cache_fill", K1, C1, 1'b0, 0, P1, 21);
        op_check("cache_same", K1, C1, 1'b1, 0, P1, CACHED_LAT);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        op_check("same_after_rst", K1, C1, 1'b1, 0, P1, 21);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  synchronous active-low reset.
REQ-004 start  input  1  request to decrypt; sampled only when busy=0.
REQ-005 Key  input  [0:127]  AES-128 cipher key; bit 0 is the MSB of byte 0.
REQ-006 Data_In  input  [0:127]  ciphertext block in FIPS-197 byte order, column-major.
REQ-007 key_same  input  1  reuse the cached key schedule; used only with the macro in REQ-021.
REQ-008 busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-009 done  output  1  one-cycle pulse marking Data_Out as valid.
REQ-010 Data_Out  output  [0:127]  recovered plaintext; held until the next accepted start.

Function
REQ-011 The FSM SHALL use the states IDLE, KEY_EXP, INIT, ROUND, FINAL and DONE.
REQ-012 When start=1 in IDLE, Data_In and Key SHALL be registered at that edge (edge 0), and the FSM SHALL go to KEY_EXP.
REQ-013 KEY_EXP SHALL compute one round key per cycle (rk1 to rk10) from rk0 = Key, using forward expansion with Rcon, and store all 11 keys; it SHALL run for 10 edges and then go to INIT.
REQ-014 INIT SHALL load state = ciphertext XOR rk10 and set the round counter to 9.
REQ-015 ROUND SHALL compute, per cycle: InvShiftRows, then InvSubBytes, then AddRoundKey(rk[r]), then InvMixColumns.
  - The round counter r SHALL decrement each cycle.
  - After the r=1 cycle, the FSM SHALL go to FINAL.
REQ-016 FINAL SHALL compute InvShiftRows, then InvSubBytes, then AddRoundKey(rk0), register the result into Data_Out, and assert done in the following DONE cycle.
REQ-017 Latency SHALL be exactly 21 rising edges from the start-sampling edge to the edge where done and Data_Out are updated, with continuous data and no gaps.
REQ-018 DONE SHALL last one cycle and return to IDLE; a start asserted during DONE SHALL be ignored.
REQ-019 A start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-020 All GF(2^8) arithmetic SHALL be modulo x^8+x^4+x^3+x+1; InvMixColumns SHALL use the coefficients {0e,0b,0d,09}.

Configuration
REQ-021 With AES_INV_KEY_CACHE_EN defined, a start with key_same=1 and a valid cache SHALL skip KEY_EXP and go straight to INIT, giving a latency of 11 edges.
  - The cache SHALL become valid when KEY_EXP completes.
REQ-022 Without AES_INV_KEY_CACHE_EN, key_same SHALL be ignored and every start SHALL run KEY_EXP.

Reset
REQ-023 When RST=0 at an edge, the block SHALL apply these reset values:
  - FSM = IDLE
  - busy = 0
  - done = 0
  - Data_Out = 128'h0
  - round counter = 0
  - key cache valid = 0
REQ-024 A reset in any state, including mid-operation, SHALL abort the decryption at that edge, with no done pulse and no update to Data_Out.
REQ-025 The round-key storage SHALL not require a reset value; validity SHALL be tracked by the cache flag alone.

Structure
REQ-026 Shared package aes_pkg SHALL hold:
  - the sbox and inv_sbox lookup functions
  - the Rcon table
  - the xtime and gf_mul functions
  - the FSM state typedef
  - the constants NR=10 and NK=4
REQ-027 A single combinational sub-module aes_inv_round SHALL implement one inverse round, with a final-round flag that bypasses InvMixColumns.
  - The FSM, counter, key schedule storage and output registers SHALL stay in aes_inv_cipher.

Verification
REQ-028 FIPS-197 C.1 vector:
  - Stimulus: Key=000102030405060708090a0b0c0d0e0f, Data_In=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse.
  - Response: done on edge 21 and Data_Out=00112233445566778899aabbccddeeff.
REQ-029 FIPS-197 Appendix B vector:
  - Stimulus: Key=2b7e151628aed2a6abf7158809cf4f3c, Data_In=3925841d02dc09fbdc118597196a0b32.
  - Response: Data_Out=3243f6a8885a308d313198a2e0370734.
REQ-030 Start while busy:
  - Stimulus: a second start with different data at edge 5.
  - Response: ignored; a single done at edge 21 with the first result; busy high throughout.
REQ-031 Reset mid-operation:
  - Stimulus: RST=0 at edge 12, then a new start.
  - Response: no done pulse; Data_Out=0; the new start completes correctly in 21 edges.
REQ-032 With the macro defined:
  - Stimulus: back-to-back C.1 decrypts, the second with key_same=1.
  - Response: the second done arrives 11 edges after its start with the correct plaintext.
  - After a reset, a key_same=1 start SHALL still take 21 edges.
